// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion sequencer and its helpers.
package sar_pkg;

    localparam int   SAR_NBITS     = 16;
    localparam int   SAR_CW        = 8;
    localparam logic SAR_MODE_AUTO = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_INIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_COMP   = 3'd4,
        ST_UPDATE = 3'd5,
        ST_DONE   = 3'd6
    } sar_state_e;

endpackage

// File: rtl/sar_cycle_timer.sv
// Loadable down-counter; o_expired is high once the count has reached zero.
module sar_cycle_timer
    import sar_pkg::*;
#(
    parameter int CW = SAR_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_expired
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/sar_sequencer.sv
// SAR timing controller: walks sampling, init, settle/comp/update per bit, then
// publishes the captured word through a valid/ready port with sticky overrun.
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int Nbits = SAR_NBITS,
    parameter int CW    = SAR_CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CW-1:0]    cfg_samp_cycles,
    input  logic [CW-1:0]    cfg_settle_cycles,
    input  logic             cfg_cont,
    input  logic             comp_in,
    output logic             seq_samp,
    output logic             seq_init,
    output logic             seq_update,
    output logic             seq_comp,
    output logic             busy,
    output logic [Nbits-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun,
    output sar_state_e       dbg_state
);

    localparam int KW = (Nbits > 1) ? $clog2(Nbits) : 1;

    sar_state_e       r_state, w_state_next, w_after_bit;
    logic [KW-1:0]    r_bit;
    logic [Nbits-1:0] r_shadow, r_result;
    logic [CW-1:0]    r_settle;
    logic             r_cont;
    logic             r_samp, r_init, r_comp, r_update, r_busy, r_valid, r_ovr;
    logic             w_samp_d, w_init_d, w_comp_d, w_update_d, w_busy_d;
    logic             w_enter_samp, w_enter_settle, w_tmr_load, w_tmr_expired;
    logic [CW-1:0]    w_tmr_val;
    logic             w_hs, w_done;

    // One timer serves both SAMPLE and SETTLE; it is reloaded on entry to either.
    assign w_enter_samp   = (w_state_next == ST_SAMPLE) && (r_state != ST_SAMPLE);
    assign w_enter_settle = (w_state_next == ST_SETTLE) && (r_state != ST_SETTLE);
    assign w_tmr_load     = w_enter_samp || w_enter_settle;
    assign w_tmr_val      = w_enter_samp
                          ? ((cfg_samp_cycles == '0) ? '0 : cfg_samp_cycles - CW'(1))
                          : r_settle - CW'(1);

    sar_cycle_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    assign w_after_bit = (r_settle != '0) ? ST_SETTLE : ST_COMP;

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start) w_state_next = ST_SAMPLE;
                ST_SAMPLE: if (w_tmr_expired) w_state_next = ST_INIT;
                ST_INIT:   w_state_next = w_after_bit;
                ST_SETTLE: if (w_tmr_expired) w_state_next = ST_COMP;
                ST_COMP:   w_state_next = ST_UPDATE;
                ST_UPDATE: w_state_next = (r_bit == '0) ? ST_DONE : w_after_bit;
                ST_DONE:   w_state_next = r_cont ? ST_SAMPLE : ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state so each register lines up with its state.
    always_comb begin
        w_samp_d   = (w_state_next == ST_SAMPLE);
        w_init_d   = (w_state_next == ST_INIT);
        w_comp_d   = (w_state_next == ST_COMP);
        w_update_d = (w_state_next == ST_UPDATE);
        w_busy_d   = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp   <= 1'b0;
            r_init   <= 1'b0;
            r_comp   <= 1'b0;
            r_update <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_samp   <= w_samp_d;
            r_init   <= w_init_d;
            r_comp   <= w_comp_d;
            r_update <= w_update_d;
            r_busy   <= w_busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_cont   <= 1'b0;
            r_bit    <= KW'(Nbits - 1);
            r_shadow <= '0;
        end else begin
            if (w_enter_samp) begin
                r_settle <= cfg_settle_cycles;
                r_cont   <= cfg_cont;
            end
            if (abort) begin
                r_bit    <= KW'(Nbits - 1);
                r_shadow <= '0;
            end else if (r_state == ST_INIT) begin
                r_bit <= KW'(Nbits - 1);
            end else if (r_state == ST_UPDATE) begin
                r_shadow[r_bit] <= comp_in;
                if (r_bit != '0) r_bit <= r_bit - KW'(1);
            end
        end
    end

    assign w_hs   = r_valid && result_ready;
    assign w_done = (r_state == ST_DONE) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_done) begin
                r_result <= r_shadow;
                r_valid  <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (abort || ((r_state == ST_IDLE) && start)) begin
                r_ovr <= 1'b0;
            end else if (w_done && r_valid && !w_hs) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign seq_samp     = r_samp;
    assign seq_init     = r_init;
    assign seq_comp     = r_comp;
    assign seq_update   = r_update;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign overrun      = r_ovr;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_sar_sequencer.sv
// Self-checking bench for sar_sequencer: strobe timing derived from the phase
// arithmetic, result/overrun tracked with an expected-result queue.
module tb_sar_sequencer;
    import sar_pkg::*;

    localparam int NB = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_samp_cycles;
    logic [CW-1:0] cfg_settle_cycles;
    logic          cfg_cont;
    logic          comp_in;
    logic          seq_samp, seq_init, seq_update, seq_comp, busy;
    logic [NB-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          overrun;
    sar_state_e    dbg_state;

    int            n_vec = 0;
    int            n_err = 0;
    int            rdy_mode = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] exp_res = '0;
    logic          exp_ovr = 1'b0;

    sar_sequencer #(.Nbits(NB), .CW(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .cfg_samp_cycles  (cfg_samp_cycles),
        .cfg_settle_cycles(cfg_settle_cycles),
        .cfg_cont         (cfg_cont),
        .comp_in          (comp_in),
        .seq_samp         (seq_samp),
        .seq_init         (seq_init),
        .seq_update       (seq_update),
        .seq_comp         (seq_comp),
        .busy             (busy),
        .result           (result),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .overrun          (overrun),
        .dbg_state        (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {busy, samp, init, comp, update} in cycle n after the accepting cycle 0.
    function automatic logic [4:0] exp_strobes(input int n, input int s, input int t);
        int sx, done, m, r;
        logic [4:0] e;
        e    = '0;
        sx   = (s == 0) ? 1 : s;
        done = sx + 1 + NB * (t + 2) + 1;
        if (n >= 1 && n <= done) e[4] = 1'b1;
        if (n >= 1 && n <= sx)   e[3] = 1'b1;
        if (n == sx + 1)         e[2] = 1'b1;
        if (n >= sx + 2 && n < done) begin
            m = n - sx - 2;
            r = m % (t + 2);
            e[1] = (r == t);
            e[0] = (r == t + 1);
        end
        return e;
    endfunction

    task automatic zero_check();
        chk("rst_samp",   seq_samp,     0);
        chk("rst_init",   seq_init,     0);
        chk("rst_comp",   seq_comp,     0);
        chk("rst_update", seq_update,   0);
        chk("rst_busy",   busy,         0);
        chk("rst_valid",  result_valid, 0);
        chk("rst_result", result,       0);
        chk("rst_ovr",    overrun,      0);
    endtask

    // One clock cycle: drive, check at negedge, then advance the result model.
    task automatic cycle(input logic st, input logic ab, input logic cin,
                         input logic [4:0] e, input bit done_now, input logic [NB-1:0] code);
        bit hs;
        @(posedge clk);
        #1;
        start        = st;
        abort        = ab;
        comp_in      = cin;
        result_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        @(negedge clk);
        chk("busy",   busy,       e[4]);
        chk("samp",   seq_samp,   e[3]);
        chk("init",   seq_init,   e[2]);
        chk("comp",   seq_comp,   e[1]);
        chk("update", seq_update, e[0]);
        chk("valid",  result_valid, (exp_q.size() != 0));
        chk("result", result,     exp_res);
        chk("ovr",    overrun,    exp_ovr);
        hs = (exp_q.size() != 0) && result_ready;
        if (hs) void'(exp_q.pop_front());
        if (done_now) begin
            if (exp_q.size() != 0) exp_ovr = 1'b1;
            exp_q.delete();
            exp_q.push_back(code);
            exp_res = code;
        end
        if (ab || (st && !e[4])) exp_ovr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'($urandom), 5'b0, 1'b0, '0);
    endtask

    // Drive one conversion; cfg switches to the ns/nt/nc values from cycle 2 onward.
    task automatic run_conv(input int s, input int t, input logic cont, input logic [NB-1:0] code,
                            input bit do_start, input int ns, input int nt, input logic nc,
                            input int abort_k, input int rst_at);
        int sx, done, m, bi, abort_n;
        logic [4:0] e;
        logic cin, st, ab;
        sx      = (s == 0) ? 1 : s;
        done    = sx + 2 + NB * (t + 2);
        abort_n = (abort_k > 0) ? sx + 1 + abort_k * (t + 2) : -1;
        if (do_start) begin
            cfg_samp_cycles   = CW'(s);
            cfg_settle_cycles = CW'(t);
            cfg_cont          = cont;
            cycle(1'b1, 1'b0, 1'($urandom), 5'b0, 1'b0, code);
        end
        for (int n = 1; n <= done; n++) begin
            if (n == 2) begin
                cfg_samp_cycles   = CW'(ns);
                cfg_settle_cycles = CW'(nt);
                cfg_cont          = nc;
            end
            if (n == rst_at) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                abort = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                zero_check();
                exp_q.delete();
                exp_res = '0;
                exp_ovr = 1'b0;
                return;
            end
            e   = exp_strobes(n, s, t);
            cin = 1'($urandom);
            if (e[0]) begin
                m   = n - sx - 2;
                bi  = NB - 1 - m / (t + 2);
                cin = code[bi];
            end
            ab = (n == abort_n);
            st = ($urandom_range(0, 3) == 0);
            cycle(st, ab, cin, e, n == done, code);
            if (ab) return;
        end
    endtask

    initial begin
        int cs, ct, ns, nt;
        logic cc, nc;
        bit chained;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        comp_in = 1'b0;
        result_ready = 1'b0;
        cfg_samp_cycles = '0;
        cfg_settle_cycles = '0;
        cfg_cont = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        zero_check();
        rst_n = 1'b1;

        // basic timing and data capture, then one-cycle handshake
        idle(2);
        run_conv(4, 1, 1'b0, 16'hA5C3, 1'b1, 4, 1, 1'b0, 0, -1);
        idle(1);
        rdy_mode = 1;
        idle(2);

        // zero-length sample and settle phases
        run_conv(0, 0, 1'b0, NB'($urandom), 1'b1, 0, 0, 1'b0, 0, -1);
        idle(2);

        // continuous mode into an unread result, then drain without clearing overrun
        rdy_mode = 0;
        run_conv(2, 1, 1'b1, 16'h1234, 1'b1, 3, 0, 1'b0, 0, -1);
        run_conv(3, 0, 1'b0, 16'hBEEF, 1'b0, 5, 2, 1'b0, 0, -1);
        idle(2);
        rdy_mode = 1;
        idle(1);
        rdy_mode = 0;
        idle(2);

        // abort at the 5th update keeps the previous result; start+abort stays idle
        run_conv(1, 2, 1'b0, 16'h0F5A, 1'b1, 1, 2, 1'b0, 0, -1);
        run_conv(4, 1, 1'b0, 16'hFFFF, 1'b1, 4, 1, 1'b0, 5, -1);
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 5'b0, 1'b0, '0);
        idle(2);

        // asynchronous reset mid-conversion, then a clean conversion
        run_conv(4, 1, 1'b0, 16'h5555, 1'b1, 4, 1, 1'b0, 0, 20);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_conv(4, 1, 1'b0, 16'h8001, 1'b1, 4, 1, 1'b0, 0, -1);
        idle(2);

        // randomized configurations, codes, continuous chains and ready
        rdy_mode = 2;
        cs = $urandom_range(0, 5);
        ct = $urandom_range(0, 3);
        cc = 1'($urandom_range(0, 1));
        chained = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ns = $urandom_range(0, 5);
            nt = $urandom_range(0, 3);
            nc = (i < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!chained) idle($urandom_range(1, 3));
            run_conv(cs, ct, cc, NB'($urandom), !chained, ns, nt, nc, 0, -1);
            chained = cc;
            cs = ns;
            ct = nt;
            cc = nc;
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_sequencer.md
Name: sar_sequencer

Overview:
Timing controller for the SAR logic block. It generates the sampling, init, comparator-strobe and update pulses that walk the SAR register from MSB to LSB. It also captures the comparator decision for each bit into a result word and hands that word off through a valid/ready handshake. It sits between the readout/config interface and sar_logic, which runs with mode=1 (auto bit-cycling).

Parameters:
Nbits, 16, conversion width; must match sar_logic Nbits
CW, 8, width of the cycle-count configuration fields

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request one conversion; accepted only in IDLE
abort  in  1  return to IDLE from any state
cfg_samp_cycles  in  CW  sampling-phase length in cycles; 0 is treated as 1
cfg_settle_cycles  in  CW  DAC settle cycles before each comparator strobe; 0 is allowed
cfg_cont  in  1  continuous mode: restart sampling automatically after DONE
comp_in  in  1  comparator decision, valid in the cycle after seq_comp
seq_samp  out  1  sampling-switch enable
seq_init  out  1  to sar_logic seq_init
seq_update  out  1  to sar_logic seq_update
seq_comp  out  1  comparator latch strobe
busy  out  1  high in every state except IDLE
result  out  Nbits  last completed conversion, MSB first
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
overrun  out  1  sticky flag: an unread result was overwritten

Behaviour:
- All outputs are registered. Reset values: every output is 0; state=IDLE; bit counter=Nbits-1.
- cfg_samp_cycles, cfg_settle_cycles and cfg_cont are latched on entry to SAMPLE. Changes during a conversion have no effect until the next SAMPLE entry.
- States: IDLE, SAMPLE, INIT, SETTLE, COMP, UPDATE, DONE.
- IDLE: when start=1 and abort=0, go to SAMPLE in the next cycle.
- SAMPLE: seq_samp=1 for max(S,1) cycles, then go to INIT.
- INIT: seq_init=1 for 1 cycle. Bit counter k=Nbits-1. Next state is SETTLE if T>0, otherwise COMP.
- SETTLE: hold for T cycles with all strobes low, then go to COMP.
- COMP: seq_comp=1 for 1 cycle, then go to UPDATE.
- UPDATE: seq_update=1 for 1 cycle. In this cycle comp_in is sampled into the shadow bit shadow[k]. If k==0 go to DONE; otherwise k<=k-1 and go to SETTLE (or COMP if T=0).
- DONE (1 cycle): result<=shadow and result_valid<=1. Next state is SAMPLE if the latched cfg_cont=1, otherwise IDLE.
- Conversion latency: with start asserted in cycle 0, DONE occurs in cycle max(S,1)+1+Nbits*(T+2)+1, and result_valid is high from the following cycle.
- Handshake: result_valid stays high until a cycle with result_valid & result_ready, after which it clears. result is stable while result_valid=1 except on overrun.
- Overrun: if DONE occurs while result_valid=1 and no handshake happens in that cycle, result is overwritten, result_valid stays 1 and overrun<=1. If the handshake and DONE coincide, the new result is loaded, result_valid stays 1 and there is no overrun.
- overrun clears on a start accepted in IDLE or on abort.
- abort has priority over all other inputs. The next state is IDLE; all seq_* strobes go low the following cycle; shadow is discarded. result and result_valid are unchanged.
- Simultaneous start and abort in IDLE: stay in IDLE and clear overrun.
- start outside IDLE is ignored; start is not queued.
- Reset mid-conversion: all outputs clear immediately (asynchronously). The seq_* strobes are never high in the same cycle as one another.

Decomposition:
- Shared package sar_pkg holds:
  - the state enum
  - the Nbits default
  - the CW default
  - the constant SAR_MODE_AUTO=1'b1 used when tying sar_logic mode.
- One sub-module, sar_cycle_timer, is a down-counter with load/expire. It is reused for both the SAMPLE and SETTLE phases.
- The FSM, bit counter, shadow register and handshake logic stay in sar_sequencer.

Test Plan:
1. Basic timing: Nbits=16, S=4, T=1, start pulse at cycle 0 → seq_samp high in cycles 1-4, seq_init at 5, first seq_comp at 7, first seq_update at 8, sixteen seq_update pulses in total, DONE at 54, result_valid from cycle 55.
2. Data capture: comp_in driven from a model with code 16'hA5C3, result_ready=1 → result=16'hA5C3 and the handshake clears result_valid one cycle later. A chained sar_logic instance ends with dac_state=16'hA5C3 in the cycle after DONE.
3. Zero-length phases: S=0, T=0 → SAMPLE lasts 1 cycle, seq_comp and seq_update alternate every cycle, DONE occurs 1+1+32+1=35 cycles after start.
4. Continuous mode with overrun: cfg_cont=1 and result_ready=0 → second DONE keeps result_valid=1, overrun=1 and result equals the second code. Then result_ready=1 for 1 cycle → result_valid drops and overrun stays 1 until the next accepted start.
5. Abort mid-conversion: abort at the 5th seq_update → IDLE next cycle, busy=0, no further strobes, previous result and result_valid unchanged. Start plus abort in the same cycle → stays in IDLE.
6. Async reset at cycle 20 of a conversion: all outputs are 0 immediately. After rst_n release and a new start, the standard latency from test 1 holds; a start while busy is ignored.
